decoder_scan_nx: RTL and testbench

- Parametrised registered successor to the 2-to-4 decoder: SEL_W-to-2^SEL_W one-hot decoder with registered outputs, enable and selectable output polarity.
- Adds a second mode: an auto-scan sequencer that walks a single active output across all 2^SEL_W lines, with a programmable dwell time per line.
- Used for row/digit strobing, such as multiplexed LED/7-seg digit select and keypad row drive, and for registered address decode.

---
 rtl/decoder_scan_nx_if.sv | 29 ++
 rtl/decoder_scan_nx.sv | 141 ++++++++++++++
 tb/tb_decoder_scan_nx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_nx_if.sv
// Bus bundle for decoder_scan_nx: the decode/scan request inputs and the registered line outputs.
interface decoder_scan_nx_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic               y_valid;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               done;

  modport master (
    output en, mode, sel, in_valid, start, dwell,
    input  y, y_valid, idx, busy, done
  );

  modport slave (
    input  en, mode, sel, in_valid, start, dwell,
    output y, y_valid, idx, busy, done
  );
endinterface

// File: rtl/decoder_scan_nx.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with an auto-scan sequencer
// that walks one active line across all outputs, each held for dwell+1 cycles.

// One output line: owns its own flop so y never glitches between states.
module decoder_scan_nx_lane #(
  parameter int SEL_W      = 2,
  parameter int LANE       = 0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_act,
  input  logic [SEL_W-1:0] i_idx,
  output logic             o_y
);
  logic w_hot;
  logic r_y;

  assign w_hot = i_act && (i_idx == SEL_W'(LANE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_y <= ACTIVE_LOW;
    else          r_y <= w_hot ^ ACTIVE_LOW;
  end

  assign o_y = r_y;
endmodule

module decoder_scan_nx #(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  decoder_scan_nx_if.slave     bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt,   w_cnt_nxt;
  logic [DWELL_W-1:0] r_d,     w_d_nxt;
  logic [SEL_W-1:0]   r_idx,   w_idx_nxt;
  logic               r_act,   w_act_nxt;
  logic               r_yv,    w_yv_nxt;
  logic               r_done,  w_done_nxt;
  logic [OUT_W-1:0]   w_y;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_idx   <= '0;
      r_act   <= 1'b0;
      r_yv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_idx   <= w_idx_nxt;
      r_act   <= w_act_nxt;
      r_yv    <= w_yv_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d;
    w_idx_nxt   = r_idx;
    w_act_nxt   = r_act;
    w_yv_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    if (!bus.en) begin
      // abort wins over a completion landing in the same cycle
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_act_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!bus.mode && bus.in_valid) begin
            w_idx_nxt = bus.sel;
            w_act_nxt = 1'b1;
            w_yv_nxt  = 1'b1;
          end else if (bus.mode && bus.start) begin
            w_state_nxt = S_SCAN;
            w_d_nxt     = bus.dwell;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_act_nxt   = 1'b1;
          end
        end
        S_SCAN: begin
          if (r_cnt == r_d) begin
            w_cnt_nxt = '0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = '0;
              w_act_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Each lane registers its bit from the next-state index, keeping y aligned with idx.
  for (genvar g = 0; g < OUT_W; g++) begin : g_lane
    decoder_scan_nx_lane #(
      .SEL_W      (SEL_W),
      .LANE       (g),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_act   (w_act_nxt),
      .i_idx   (w_idx_nxt),
      .o_y     (w_y[g])
    );
  end

  assign bus.y       = w_y;
  assign bus.y_valid = r_yv;
  assign bus.idx     = r_idx;
  assign bus.busy    = (r_state == S_SCAN);
  assign bus.done    = r_done;
endmodule

// File: tb/tb_decoder_scan_nx.sv
// Bench for decoder_scan_nx: directed vector table, scan/abort sequences,
// randomized traffic against a timeline-based reference model, and a wide active-low instance.
module tb_decoder_scan_nx;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  decoder_scan_nx_if #(.SEL_W(2), .DWELL_W(4)) a ();
  decoder_scan_nx_if #(.SEL_W(3), .DWELL_W(4)) b ();

  decoder_scan_nx #(.SEL_W(2), .DWELL_W(4), .ACTIVE_LOW(1'b0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(a.slave));
  decoder_scan_nx #(.SEL_W(3), .DWELL_W(4), .ACTIVE_LOW(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst2_n), .bus(b.slave));

  int n_pass = 0, n_tot = 0;
  int nbusy = 0, ndone = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a scan is a timeline; e edges after the start edge, line = e/(D+1).
  int m_line = -1, m_idx = 0, m_e = 0, m_D = 0;
  bit m_scan = 0, m_yv = 0, m_done = 0;

  task automatic model_step(input logic r, en, mode, input logic [1:0] sel,
                            input logic iv, st, input logic [3:0] dw);
    m_yv = 0; m_done = 0;
    if (!r) begin
      m_line = -1; m_idx = 0; m_scan = 0;
    end else if (!en) begin
      m_line = -1; m_idx = 0; m_scan = 0;
    end else if (m_scan) begin
      m_e++;
      if (m_e == 4 * (m_D + 1)) begin
        m_line = -1; m_idx = 0; m_scan = 0; m_done = 1;
      end else begin
        m_line = m_e / (m_D + 1); m_idx = m_line;
      end
    end else if (!mode && iv) begin
      m_line = int'(sel); m_idx = int'(sel); m_yv = 1;
    end else if (mode && st) begin
      m_scan = 1; m_e = 0; m_D = int'(dw); m_line = 0; m_idx = 0;
    end
  endtask

  function automatic logic [8:0] model_pack();
    logic [3:0] y;
    y = (m_line < 0) ? 4'b0000 : 4'(1 << m_line);
    return {y, 2'(m_idx), m_yv, m_scan, m_done};
  endfunction

  task automatic drive(input logic r, en, mode, input logic [1:0] sel,
                       input logic iv, st, input logic [3:0] dw);
    rst_n = r; a.en = en; a.mode = mode; a.sel = sel;
    a.in_valid = iv; a.start = st; a.dwell = dw;
  endtask

  task automatic cyc(input string nm, input logic r, en, mode, input logic [1:0] sel,
                     input logic iv, st, input logic [3:0] dw);
    drive(r, en, mode, sel, iv, st, dw);
    @(posedge clk);
    model_step(r, en, mode, sel, iv, st, dw);
    #1;
    chk(nm, {23'd0, a.y, a.idx, a.y_valid, a.busy, a.done}, {23'd0, model_pack()});
    nbusy += int'(a.busy);
    ndone += int'(a.done);
  endtask

  typedef struct {
    logic rst_n, en, mode; logic [1:0] sel; logic iv, st; logic [3:0] dw;
    logic [3:0] y; logic [1:0] idx; logic yv, busy, done;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,4'd0, 4'b0000,2'd0,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,4'd0, 4'b0000,2'd0,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b0,2'd0,1'b1,1'b0,4'd0, 4'b0001,2'd0,1'b1,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,4'd0, 4'b0010,2'd1,1'b1,1'b0,1'b0};
    tbl[4] = '{1'b1,1'b1,1'b0,2'd2,1'b1,1'b0,4'd0, 4'b0100,2'd2,1'b1,1'b0,1'b0};
    tbl[5] = '{1'b1,1'b1,1'b0,2'd3,1'b1,1'b0,4'd0, 4'b1000,2'd3,1'b1,1'b0,1'b0};
    tbl[6] = '{1'b1,1'b1,1'b0,2'd1,1'b0,1'b0,4'd0, 4'b1000,2'd3,1'b0,1'b0,1'b0};
    tbl[7] = '{1'b1,1'b0,1'b0,2'd1,1'b1,1'b0,4'd0, 4'b0000,2'd0,1'b0,1'b0,1'b0};
    tbl[8] = '{1'b1,1'b1,1'b1,2'd2,1'b1,1'b0,4'd0, 4'b0000,2'd0,1'b0,1'b0,1'b0};
    tbl[9] = '{1'b1,1'b1,1'b0,2'd1,1'b1,1'b1,4'd3, 4'b0010,2'd1,1'b1,1'b0,1'b0};

    rst2_n = 1'b0; b.en = 1'b1; b.mode = 1'b0; b.sel = '0;
    b.in_valid = 1'b0; b.start = 1'b0; b.dwell = '0;

    // Directed table: reset, decode sweep, hold, enable-off, mode gating.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].iv, tbl[i].st, tbl[i].dw);
      @(posedge clk);
      model_step(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].iv, tbl[i].st, tbl[i].dw);
      #1;
      chk($sformatf("vec%0d", i), {23'd0, a.y, a.idx, a.y_valid, a.busy, a.done},
          {23'd0, tbl[i].y, tbl[i].idx, tbl[i].yv, tbl[i].busy, tbl[i].done});
    end

    // Scan D=1 with a stray start mid-scan.
    nbusy = 0; ndone = 0;
    cyc("scan1_start", 1,1,1,0,0,1,4'd1);
    for (int i = 0; i < 8; i++) cyc("scan1", 1,1,1,0,0,(i == 2),4'd1);
    chk("scan1_busy_cycles", nbusy, 8);
    chk("scan1_done_pulses", ndone, 1);
    chk("scan1_end_y", {28'd0, a.y}, 0);

    // Scan D=0, then a restart on the done cycle with D=15.
    nbusy = 0; ndone = 0;
    cyc("scan0_start", 1,1,1,0,0,1,4'd0);
    for (int i = 0; i < 4; i++) cyc("scan0", 1,1,1,0,0,0,4'd0);
    chk("scan0_busy_cycles", nbusy, 4);
    chk("scan0_done_pulses", ndone, 1);
    chk("scan0_done_now", {31'd0, a.done}, 1);
    nbusy = 0; ndone = 0;
    cyc("scan15_start", 1,1,1,0,0,1,4'd15);
    for (int i = 0; i < 64; i++) cyc("scan15", 1,1,1,0,0,0,4'd0);
    chk("scan15_busy_cycles", nbusy, 64);
    chk("scan15_done_pulses", ndone, 1);

    // Abort with en=0 while idx=2.
    nbusy = 0; ndone = 0;
    cyc("abort_start", 1,1,1,0,0,1,4'd1);
    for (int i = 0; i < 4; i++) cyc("abort_run", 1,1,1,0,0,0,4'd1);
    chk("abort_idx_before", {30'd0, a.idx}, 2);
    cyc("abort_en0", 1,0,1,0,0,0,4'd1);
    chk("abort_y", {28'd0, a.y}, 0);
    for (int i = 0; i < 3; i++) cyc("abort_idle", 1,1,1,0,0,0,4'd1);
    chk("abort_no_done", ndone, 0);

    // Reset mid-scan at idx=1.
    ndone = 0;
    cyc("rst_start", 1,1,1,0,0,1,4'd1);
    for (int i = 0; i < 2; i++) cyc("rst_run", 1,1,1,0,0,0,4'd1);
    chk("rst_idx_before", {30'd0, a.idx}, 1);
    cyc("rst_mid", 0,1,1,0,0,0,4'd1);
    chk("rst_y_busy", {27'd0, a.y, a.busy}, 0);
    for (int i = 0; i < 3; i++) cyc("rst_idle", 1,1,1,0,0,0,4'd1);
    chk("rst_no_done", ndone, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] dw;
      dw = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      cyc("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 29) != 0),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), dw);
    end

    // Wide active-low instance: reset pattern, decode sel=5, hold.
    @(posedge clk); @(posedge clk); #1;
    chk("al_reset_y", {24'd0, b.y}, 32'hFF);
    chk("al_reset_idx", {29'd0, b.idx}, 0);
    rst2_n = 1'b1; b.sel = 3'd5; b.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("al_dec5_y", {24'd0, b.y}, 32'hDF);
    chk("al_dec5_idx_vld", {28'd0, b.idx, b.y_valid}, {28'd0, 3'd5, 1'b1});
    b.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("al_hold", {23'd0, b.y, b.y_valid}, {23'd0, 8'hDF, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
